// File: rtl/ram_bus_port.sv
// Host req/ack bus to word-indexed RAM port adapter; partial-byte writes run as read-modify-write.
// Latency: full write 1 cycle, read resp 2 cycles after ack, partial write 2 cycles; ack only in IDLE.
// Build option RAM_BUS_PORT_RANGE_CHECK_EN: out-of-range words are acked but ignored and set sticky host_err.
module ram_bus_port #(
  parameter int dat_width = 32,
  parameter int adr_width = 32,
  parameter int mem_size  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_req,
  output logic                   host_ack,
  input  logic                   host_we,
  input  logic [adr_width-1:0]   host_addr,
  input  logic [dat_width/8-1:0] host_be,
  input  logic [dat_width-1:0]   host_wdata,
  output logic                   host_resp,
  output logic [dat_width-1:0]   host_rdata,
  output logic                   host_err,
  output logic [adr_width-1:0]   ram_adr_o,
  output logic                   ram_we_o,
  output logic [dat_width-1:0]   ram_dat_o,
  input  logic [dat_width-1:0]   ram_dat_i
);

  localparam int BE_W  = dat_width / 8;
  localparam int SHIFT = $clog2(BE_W);
  localparam logic [adr_width:0] MEM_LIMIT = (adr_width + 1)'(mem_size);

`ifdef RAM_BUS_PORT_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_MERGE} state_t;

  state_t                 state_q, state_d;
  logic [adr_width-1:0]   adr_q, adr_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic [dat_width-1:0]   wdata_q, wdata_d;
  logic                   oor_q, oor_d;
  logic                   resp_q, resp_d;
  logic [dat_width-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [adr_width-1:0]   idx;
  logic                   oor;
  logic                   we_c;

  assign idx = host_addr >> SHIFT;
  assign oor = RANGE_CHK && ({1'b0, idx} >= MEM_LIMIT);

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    resp_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    host_ack  = 1'b0;
    ram_adr_o = idx;
    we_c      = 1'b0;
    ram_dat_o = host_wdata;

    case (state_q)
      IDLE: begin
        if (host_req) begin
          host_ack = 1'b1;
          err_d    = err_q | oor;
          if (!host_we) begin
            state_d = RD_WAIT;
            adr_d   = idx;
            oor_d   = oor;
          end else if (!oor && (|host_be)) begin
            if (&host_be) begin
              we_c = 1'b1;
            end else begin
              // The RAM read for the merge is issued now via ram_adr_o = idx.
              adr_d   = idx;
              be_d    = host_be;
              wdata_d = host_wdata;
              state_d = RMW_MERGE;
            end
          end
        end
      end
      RD_WAIT: begin
        ram_adr_o = adr_q;
        resp_d    = 1'b1;
        rdata_d   = oor_q ? '0 : ram_dat_i;
        state_d   = IDLE;
      end
      RMW_MERGE: begin
        ram_adr_o = adr_q;
        we_c      = 1'b1;
        for (int i = 0; i < BE_W; i++) begin
          ram_dat_o[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_dat_i[8*i +: 8];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so an interrupted merge never reaches the RAM.
  assign ram_we_o   = we_c & rst_n;
  assign host_resp  = resp_q;
  assign host_rdata = rdata_q;
  assign host_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
